uart_tx_arbiter: RTL

Round-robin scheduler that shares one UART `transmitter` between `N_REQ` byte producers, such as the Fibonacci core's result dumper and the debug monitor. It accepts one byte at a time from a requester through a valid/ready handshake, then drives the transmitter's `data_in`/`tx_start`. It waits for the transmitter's `tx_done` pulse and only then grants the next requester. A watchdog aborts a transfer when `tx_done` never arrives, so a wedged transmitter cannot lock out every producer.

---
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ byte producers.
// One byte per grant: accept, launch, wait for tx_done (or watchdog abort), rotate priority.
module uart_tx_arbiter #(
   parameter int N_REQ          = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic                        clk,
   input  logic                        arst_n,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]            req_ready,
   output logic [DATA_WIDTH-1:0]       tx_data,
   output logic                        tx_start,
   input  logic                        tx_done,
   output logic                        busy,
   output logic [$clog2(N_REQ)-1:0]    grant_id,
   output logic                        tx_timeout
);

   localparam int GW   = $clog2(N_REQ);
   localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
   localparam int WD_W = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_EN ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2
   } state_t;

   state_t                  state_r, state_nx_s;
   logic [GW-1:0]           last_grant_r, last_grant_nx_s;
   logic [GW-1:0]           grant_id_r, grant_id_nx_s;
   logic [DATA_WIDTH-1:0]   tx_data_r, tx_data_nx_s;
   logic                    tx_start_r, tx_start_nx_s;
   logic                    busy_r, busy_nx_s;
   logic [WD_W-1:0]         wd_r, wd_nx_s;
   logic                    run_r;
   logic                    found_s;
   logic [GW-1:0]           winner_s;
   logic [DATA_WIDTH-1:0]   win_data_s;
   logic [N_REQ-1:0]        req_ready_s;
   logic                    tx_timeout_s;
   logic [DATA_WIDTH-1:0]   slot_s [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_slot
      assign slot_s[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // Rotating priority search: scanning from the far end keeps the nearest hit after last_grant.
   always_comb begin : arb_search
      logic [GW-1:0] idx;
      idx      = '0;
      found_s  = 1'b0;
      winner_s = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = GW'((int'(last_grant_r) + k) % N_REQ);
         if (req_valid[idx]) begin
            found_s  = 1'b1;
            winner_s = idx;
         end else begin
            found_s  = found_s;
         end
      end
   end

   assign win_data_s = slot_s[winner_s];

   // Next-state and datapath decode for the IDLE/LAUNCH/WAIT sequence.
   always_comb begin
      state_nx_s      = state_r;
      last_grant_nx_s = last_grant_r;
      grant_id_nx_s   = grant_id_r;
      tx_data_nx_s    = tx_data_r;
      tx_start_nx_s   = 1'b0;
      busy_nx_s       = busy_r;
      wd_nx_s         = wd_r;
      req_ready_s     = '0;
      tx_timeout_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // run_r keeps req_ready low while reset is asserted even if producers are valid
            if (run_r && found_s) begin
               req_ready_s[winner_s] = 1'b1;
               tx_data_nx_s  = win_data_s;
               grant_id_nx_s = winner_s;
               tx_start_nx_s = 1'b1;
               busy_nx_s     = 1'b1;
               state_nx_s    = ST_LAUNCH;
            end else begin
               state_nx_s    = ST_IDLE;
            end
         end
         ST_LAUNCH: begin
            wd_nx_s    = '0;
            state_nx_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (tx_done) begin
               last_grant_nx_s = grant_id_r;
               busy_nx_s       = 1'b0;
               state_nx_s      = ST_IDLE;
            end else if (WD_EN && (wd_r == WD_LAST)) begin
               tx_timeout_s    = 1'b1;
               last_grant_nx_s = grant_id_r;
               busy_nx_s       = 1'b0;
               state_nx_s      = ST_IDLE;
            end else if (WD_EN) begin
               wd_nx_s         = wd_r + 1'b1;
            end else begin
               wd_nx_s         = wd_r;
            end
         end
         default: begin
            busy_nx_s  = 1'b0;
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_r      <= ST_IDLE;
         last_grant_r <= GW'(N_REQ - 1);
         grant_id_r   <= '0;
         tx_data_r    <= '0;
         tx_start_r   <= 1'b0;
         busy_r       <= 1'b0;
         wd_r         <= '0;
         run_r        <= 1'b0;
      end else begin
         state_r      <= state_nx_s;
         last_grant_r <= last_grant_nx_s;
         grant_id_r   <= grant_id_nx_s;
         tx_data_r    <= tx_data_nx_s;
         tx_start_r   <= tx_start_nx_s;
         busy_r       <= busy_nx_s;
         wd_r         <= wd_nx_s;
         run_r        <= 1'b1;
      end
   end

   assign req_ready  = req_ready_s;
   assign tx_data    = tx_data_r;
   assign tx_start   = tx_start_r;
   assign busy       = busy_r;
   assign grant_id   = grant_id_r;
   assign tx_timeout = tx_timeout_s;

endmodule
